timer_ccp_multi: RTL and testbench
==================================

// Module: timer_ccp_multi
// PURPOSE
//  Parametrised successor of the 8-bit event/prescaled counter. It provides a WIDTH-bit up-counter with event or prescaled-clock source and overflow reload.
//  It also provides NUM_CH independent channels, each configurable as input capture, output compare, or edge-aligned PWM, with per-channel flags, ACK and overrun.
//  It sits under the microcontroller-style register interface; all inputs are levels from software or pins.
// PARAMETERS
//  WIDTH   16  counter, load, capture and compare width (>=4)
//  NUM_CH  2   number of capture/compare/PWM channels (1..8)
// PORTS
//  iClk               in   1           single clock
//  iReset             in   1           synchronous, active-high reset
//  iEventos           in   1           external count-event pin (async)
//  ivInputSel         in   3           count source: 0 stop, 1 prescaled iClk, 2 any edge, 3 neg edge, 4 pos edge, 5-7 stop
//  ivDivSel           in   3           prescale divisor = 2^ivDivSel (1..128)
//  ivCountLoad        in   WIDTH       reload value
//  iLoad              in   1           immediate load strobe
//  iTimerOverflowACK  in   1           overflow flag clear (level)
//  ivChEstimulo       in   NUM_CH      capture pins (async)
//  ivChMode           in   2*NUM_CH    per channel: 00 off, 01 capture, 10 compare, 11 PWM
//  ivChEdge           in   2*NUM_CH    capture edge: 00 none, 01 rise, 10 fall, 11 both
//  ivCompareValue     in   NUM_CH*WIDTH per-channel compare value
//  ivChACK            in   NUM_CH      per-channel flag/overrun clear (level)
//  ovCuenta           out  WIDTH       counter value
//  oTimerOverflow     out  1           sticky overflow flag
//  ovChFlag           out  NUM_CH      sticky capture/compare flag
//  ovChOverrun        out  NUM_CH      sticky: capture while flag pending
//  ovCaptura          out  NUM_CH*WIDTH captured counter values
//  ovPwm              out  NUM_CH      PWM outputs (registered)
// BEHAVIOUR
//  - Reset: every output and internal register (sync flops, prescaler) is 0.
//  - Async pins: synchronised with a 2-flop synchroniser, then an edge detector.
//    - A pin transition sampled at edge k acts on edge k+2, i.e. 3 rising edges including the sampling edge.
//  - Prescaler: free-running 7-bit counter, cleared by reset and iLoad.
//    - Tick when its low ivDivSel bits are all 1 (DivSel=0: every cycle).
//  - Count tick: per ivInputSel. Stop codes hold ovCuenta.
//  - Counter priority, per cycle:
//    - iLoad: count <= ivCountLoad; no overflow.
//    - tick with count == all-ones: count <= ivCountLoad and overflow event.
//    - tick: count + 1, modulo 2^WIDTH.
//  - Flags (overflow, ChFlag, ChOverrun):
//    - Set on event.
//    - Cleared on any cycle with ACK=1 and no event; if set and ACK coincide, set wins.
//    - A level ACK held high clears each new event one cycle after it is flagged.
//  - Capture mode (01):
//    - A selected edge on the synced ivChEstimulo loads ovCaptura[ch] <= current ovCuenta, then sets the flag.
//    - If the flag is already 1 and ACK=0, the capture still overwrites and ovChOverrun sets.
//    - Capture works while the counter is stopped.
//  - Compare mode (10): the flag sets on any counter update (tick, load, reload) whose new value == compare.
//    - A held value does not re-trigger.
//  - PWM mode (11): ovPwm[ch] <= (ovCuenta < compare), registered 1 cycle.
//    - compare=0 gives constant 0.
//    - No flag activity in PWM mode.
//  - Mode 00: ChFlag, ChOverrun and ovPwm forced to 0; ovCaptura holds.
//  - Mode change: no reset of ovCaptura; flags keep state unless the new mode is 00.
//  - Reset mid-operation: everything returns to reset values the next edge; no pending event survives.
// STRUCTURE
//  - Shared include timer_defs.vh: localparams for ivInputSel codes, channel mode codes and edge codes.
//  - Sub-module sync_edge_detect (2-flop synchroniser + rise/fall/both select, registered history).
//    - 1 instance for iEventos, NUM_CH for channels.
//  - Channels built in a generate loop.
// TESTING (WIDTH=8, NUM_CH=2)
//  1. iReset held 2 cycles mid-count -> all outputs 0 next edge; count stays 0 with ivInputSel=0.
//  2. ivInputSel=4, iLoad with load=5, then 3 rising edges on iEventos -> ovCuenta=8, each +1 exactly 3 edges after the transition.
//     With ivInputSel=3, falling edges only count.
//  3. ivInputSel=1, DivSel=2, load 0xFC -> overflow after 16 cycles, ovCuenta=0xFC, oTimerOverflow=1 until ACK.
//     ACK coincident with the next overflow -> flag stays 1.
//  4. ch0 capture on rise at count 0x12 -> ovCaptura[7:0]=0x12, flag=1.
//     Second rise at 0x20 with no ACK -> ovCaptura[7:0]=0x20, overrun=1; ACK clears both.
//  5. ch1 PWM with compare=3, load=0, DivSel=0 -> ovPwm[1] high for 3 of every 256 cycles.
//     Switch to compare mode -> flag once per wrap when the count becomes 3.
//  6. load=0, compare=0, compare mode, ACK held 1 -> flag pulses 1 for one cycle at each reload; iLoad alone also sets it.

Source files
------------

// File: rtl/timer_ccp_multi_pkg.sv
// Shared codes for timer_ccp_multi: count-source select, channel mode and capture edge,
// plus the prescaler tick decode.
package timer_ccp_multi_pkg;

   localparam logic [2:0] IN_STOP  = 3'd0;
   localparam logic [2:0] IN_PRESC = 3'd1;
   localparam logic [2:0] IN_ANY   = 3'd2;
   localparam logic [2:0] IN_NEG   = 3'd3;
   localparam logic [2:0] IN_POS   = 3'd4;

   localparam logic [1:0] MODE_OFF = 2'b00;
   localparam logic [1:0] MODE_CAP = 2'b01;
   localparam logic [1:0] MODE_CMP = 2'b10;
   localparam logic [1:0] MODE_PWM = 2'b11;

   localparam logic [1:0] EDGE_NONE = 2'b00;
   localparam logic [1:0] EDGE_RISE = 2'b01;
   localparam logic [1:0] EDGE_FALL = 2'b10;
   localparam logic [1:0] EDGE_BOTH = 2'b11;

   localparam int PRESC_W = 7;

   // Tick when the low div_sel bits of the prescaler are all ones (div_sel=0 ticks every cycle).
   function automatic logic presc_tick(input logic [PRESC_W-1:0] presc,
                                       input logic [2:0]         div_sel);
      logic [PRESC_W-1:0] mask;
      mask = PRESC_W'((8'd1 << div_sel) - 8'd1);
      return (presc & mask) == mask;
   endfunction

endpackage

// File: rtl/timer_ccp_multi_sync_edge_detect.sv
// Two-flop synchroniser for an async pin followed by a registered-history edge detector;
// the edge pulse is combinational from the flops so a transition sampled at edge k acts at k+2.
module timer_ccp_multi_sync_edge_detect
   import timer_ccp_multi_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       pin_i,
   input  logic [1:0] edge_sel_i,
   output logic       edge_o
);

   logic [2:0] sh_q;   // [1:0] synchroniser, [2] history
   logic       rise, fall;

   always_ff @(posedge clk_i) begin
      if (rst_i) sh_q <= '0;
      else       sh_q <= {sh_q[1:0], pin_i};
   end

   assign rise = sh_q[1] & ~sh_q[2];
   assign fall = ~sh_q[1] & sh_q[2];

   always_comb begin
      edge_o = 1'b0;
      case (edge_sel_i)
         EDGE_NONE: edge_o = 1'b0;
         EDGE_RISE: edge_o = rise;
         EDGE_FALL: edge_o = fall;
         EDGE_BOTH: edge_o = rise | fall;
      endcase
   end

endmodule

// File: rtl/timer_ccp_multi.sv
// WIDTH-bit event/prescaled up-counter with overflow reload, plus NUM_CH channels
// each usable as input capture, output compare or edge-aligned PWM.
module timer_ccp_multi
   import timer_ccp_multi_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int NUM_CH = 2
) (
   input  logic                    iClk,
   input  logic                    iReset,
   input  logic                    iEventos,
   input  logic [2:0]              ivInputSel,
   input  logic [2:0]              ivDivSel,
   input  logic [WIDTH-1:0]        ivCountLoad,
   input  logic                    iLoad,
   input  logic                    iTimerOverflowACK,
   input  logic [NUM_CH-1:0]       ivChEstimulo,
   input  logic [2*NUM_CH-1:0]     ivChMode,
   input  logic [2*NUM_CH-1:0]     ivChEdge,
   input  logic [NUM_CH*WIDTH-1:0] ivCompareValue,
   input  logic [NUM_CH-1:0]       ivChACK,
   output logic [WIDTH-1:0]        ovCuenta,
   output logic                    oTimerOverflow,
   output logic [NUM_CH-1:0]       ovChFlag,
   output logic [NUM_CH-1:0]       ovChOverrun,
   output logic [NUM_CH*WIDTH-1:0] ovCaptura,
   output logic [NUM_CH-1:0]       ovPwm
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [WIDTH-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               tick, upd, ovf_evt, ev_edge;
   logic [1:0]         ev_sel;

   // The event pin reuses the channel edge detector; map the count-source code to an edge code.
   always_comb begin
      ev_sel = EDGE_NONE;
      case (ivInputSel)
         IN_ANY:  ev_sel = EDGE_BOTH;
         IN_NEG:  ev_sel = EDGE_FALL;
         IN_POS:  ev_sel = EDGE_RISE;
         default: ev_sel = EDGE_NONE;
      endcase
   end

   timer_ccp_multi_sync_edge_detect u_ev_sync (
      .clk_i      (iClk),
      .rst_i      (iReset),
      .pin_i      (iEventos),
      .edge_sel_i (ev_sel),
      .edge_o     (ev_edge)
   );

   always_comb begin
      tick = 1'b0;
      case (ivInputSel)
         IN_STOP:                tick = 1'b0;
         IN_PRESC:               tick = presc_tick(presc_q, ivDivSel);
         IN_ANY, IN_NEG, IN_POS: tick = ev_edge;
         default:                tick = 1'b0;
      endcase
   end

   always_comb begin
      presc_d = iLoad ? '0 : presc_q + PRESC_W'(1);
      upd     = iLoad | tick;
      ovf_evt = tick & ~iLoad & (&cnt_q);
      cnt_d   = cnt_q;
      if (iLoad || ovf_evt) cnt_d = ivCountLoad;
      else if (tick)        cnt_d = cnt_q + ONE;
      ovf_d   = ovf_evt | (ovf_q & ~iTimerOverflowACK);
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         presc_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ovCuenta       = cnt_q;
   assign oTimerOverflow = ovf_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [1:0]       mode;
      logic [WIDTH-1:0] cmp, cap_q, cap_d;
      logic             ack, cap_edge;
      logic             flag_q, flag_d, ovr_q, ovr_d, pwm_q, pwm_d;

      assign mode = ivChMode[2*g +: 2];
      assign cmp  = ivCompareValue[g*WIDTH +: WIDTH];
      assign ack  = ivChACK[g];

      timer_ccp_multi_sync_edge_detect u_cap_sync (
         .clk_i      (iClk),
         .rst_i      (iReset),
         .pin_i      (ivChEstimulo[g]),
         .edge_sel_i (ivChEdge[2*g +: 2]),
         .edge_o     (cap_edge)
      );

      // An event always wins over a coincident ACK.
      always_comb begin
         cap_d  = cap_q;
         flag_d = flag_q & ~ack;
         ovr_d  = ovr_q & ~ack;
         pwm_d  = 1'b0;
         case (mode)
            MODE_OFF: begin
               flag_d = 1'b0;
               ovr_d  = 1'b0;
            end
            MODE_CAP: if (cap_edge) begin
               cap_d  = cnt_q;
               flag_d = 1'b1;
               if (flag_q && !ack) ovr_d = 1'b1;
            end
            MODE_CMP: if (upd && cnt_d == cmp) flag_d = 1'b1;
            MODE_PWM: pwm_d = cnt_q < cmp;
         endcase
      end

      always_ff @(posedge iClk) begin
         if (iReset) begin
            cap_q  <= '0;
            flag_q <= 1'b0;
            ovr_q  <= 1'b0;
            pwm_q  <= 1'b0;
         end else begin
            cap_q  <= cap_d;
            flag_q <= flag_d;
            ovr_q  <= ovr_d;
            pwm_q  <= pwm_d;
         end
      end

      assign ovCaptura[g*WIDTH +: WIDTH] = cap_q;
      assign ovChFlag[g]                 = flag_q;
      assign ovChOverrun[g]              = ovr_q;
      assign ovPwm[g]                    = pwm_q;
   end

endmodule

// File: tb/tb_timer_ccp_multi.sv
// Randomized bench for timer_ccp_multi (WIDTH=8, NUM_CH=2) against a cycle-level model,
// with a few hand-derived directed points.
module tb_timer_ccp_multi;

   localparam int W  = 8;
   localparam int NC = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ev_pin = 1'b0;
   logic [2:0]    in_sel = 3'd0;
   logic [2:0]    div_sel = 3'd0;
   logic [W-1:0]  load_v = '0;
   logic          load = 1'b0;
   logic          ovf_ack = 1'b0;
   logic [NC-1:0] ch_pin = '0;
   logic [2*NC-1:0] ch_mode = '0;
   logic [2*NC-1:0] ch_edge = '0;
   logic [NC*W-1:0] ch_cmp = '0;
   logic [NC-1:0] ch_ack = '0;

   logic [W-1:0]    cnt;
   logic            ovf;
   logic [NC-1:0]   flag, ovr, pwm;
   logic [NC*W-1:0] cap;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   timer_ccp_multi #(.WIDTH(W), .NUM_CH(NC)) dut (
      .iClk              (clk),
      .iReset            (rst),
      .iEventos          (ev_pin),
      .ivInputSel        (in_sel),
      .ivDivSel          (div_sel),
      .ivCountLoad       (load_v),
      .iLoad             (load),
      .iTimerOverflowACK (ovf_ack),
      .ivChEstimulo      (ch_pin),
      .ivChMode          (ch_mode),
      .ivChEdge          (ch_edge),
      .ivCompareValue    (ch_cmp),
      .ivChACK           (ch_ack),
      .ovCuenta          (cnt),
      .oTimerOverflow    (ovf),
      .ovChFlag          (flag),
      .ovChOverrun       (ovr),
      .ovCaptura         (cap),
      .ovPwm             (pwm)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: pin samples are kept as a short history; a pin change between the samples
   // taken two and three edges ago is the edge acting at this edge.
   int m_cnt, m_presc;
   bit m_ovf;
   bit m_flag[NC], m_ovr[NC], m_pwm[NC];
   int m_cap[NC];
   bit eh[3];
   bit chh[NC][3];

   always @(posedge clk) begin
      bit er, ef, tk, upd, wrap, r, f, cap_ev, a;
      int nxt, md, ed, cv;
      if (rst) begin
         m_cnt = 0; m_presc = 0; m_ovf = 0;
         for (int c = 0; c < NC; c++) begin
            m_flag[c] = 0; m_ovr[c] = 0; m_pwm[c] = 0; m_cap[c] = 0;
            for (int k = 0; k < 3; k++) chh[c][k] = 0;
         end
         for (int k = 0; k < 3; k++) eh[k] = 0;
      end else begin
         er = eh[1] && !eh[2];
         ef = !eh[1] && eh[2];
         case (in_sel)
            3'd1:    tk = (m_presc % (1 << div_sel)) == ((1 << div_sel) - 1);
            3'd2:    tk = er || ef;
            3'd3:    tk = ef;
            3'd4:    tk = er;
            default: tk = 0;
         endcase
         upd = load || tk;
         wrap = 0;
         nxt = m_cnt;
         if (load) nxt = load_v;
         else if (tk) begin
            if (m_cnt + 1 == (1 << W)) begin nxt = load_v; wrap = 1; end
            else nxt = m_cnt + 1;
         end
         m_ovf = wrap ? 1'b1 : (ovf_ack ? 1'b0 : m_ovf);
         for (int c = 0; c < NC; c++) begin
            md = ch_mode[2*c +: 2];
            ed = ch_edge[2*c +: 2];
            cv = ch_cmp[W*c +: W];
            a  = ch_ack[c];
            r  = chh[c][1] && !chh[c][2];
            f  = !chh[c][1] && chh[c][2];
            cap_ev = (ed == 1 && r) || (ed == 2 && f) || (ed == 3 && (r || f));
            m_pwm[c] = (md == 3) && (m_cnt < cv);
            if (md == 0) begin
               m_flag[c] = 0; m_ovr[c] = 0;
            end else if (md == 1 && cap_ev) begin
               m_cap[c] = m_cnt;
               m_ovr[c] = (m_flag[c] && !a) ? 1'b1 : (a ? 1'b0 : m_ovr[c]);
               m_flag[c] = 1;
            end else if (md == 2 && upd && nxt == cv) begin
               m_flag[c] = 1;
               m_ovr[c] = a ? 1'b0 : m_ovr[c];
            end else begin
               m_flag[c] = a ? 1'b0 : m_flag[c];
               m_ovr[c] = a ? 1'b0 : m_ovr[c];
            end
         end
         m_presc = load ? 0 : (m_presc + 1) % 128;
         m_cnt = nxt;
         eh[2] = eh[1]; eh[1] = eh[0]; eh[0] = ev_pin;
         for (int c = 0; c < NC; c++) begin
            chh[c][2] = chh[c][1]; chh[c][1] = chh[c][0]; chh[c][0] = ch_pin[c];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cnt", 32'(cnt), 32'(m_cnt));
         chk("ovf", 32'(ovf), 32'(m_ovf));
         chk("flag", 32'(flag), 32'({m_flag[1], m_flag[0]}));
         chk("ovr", 32'(ovr), 32'({m_ovr[1], m_ovr[0]}));
         chk("pwm", 32'(pwm), 32'({m_pwm[1], m_pwm[0]}));
         chk("cap", 32'(cap), {16'h0, m_cap[1][7:0], m_cap[0][7:0]});
      end
   end

   initial begin
      // reset mid-count
      @(posedge clk); #2;
      rst = 0; in_sel = 3'd1; div_sel = 3'd0;
      @(negedge clk); chk_en = 1;
      repeat (10) @(posedge clk);
      #2 rst = 1;
      repeat (2) @(posedge clk);
      #2 rst = 0; in_sel = 3'd0;
      @(negedge clk);
      chk("rst_cnt", 32'(cnt), 32'h0);
      chk("rst_outs", 32'({ovf, flag, ovr, pwm, cap}), 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk); chk("stop_cnt", 32'(cnt), 32'h0);

      // prescaled overflow and ACK/set collision
      @(posedge clk); #2;
      in_sel = 3'd1; div_sel = 3'd2; load_v = 8'hFC; load = 1;
      @(posedge clk); #2 load = 0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("pre_ovf_cnt", 32'(cnt), 32'hFF);
      chk("pre_ovf_flag", 32'(ovf), 32'h0);
      @(posedge clk);
      @(negedge clk);
      chk("ovf_cnt", 32'(cnt), 32'hFC);
      chk("ovf_flag", 32'(ovf), 32'h1);
      repeat (15) @(posedge clk);
      #2 ovf_ack = 1;
      @(posedge clk);
      @(negedge clk); chk("ovf_set_wins", 32'(ovf), 32'h1);
      @(posedge clk); #2 ovf_ack = 0;
      @(negedge clk); chk("ovf_ack_clr", 32'(ovf), 32'h0);

      // capture on stopped counter, then overrun
      @(posedge clk); #2;
      in_sel = 3'd0; ch_mode = 4'b0001; ch_edge = 4'b0001; load_v = 8'h12; load = 1;
      @(posedge clk); #2 load = 0; ch_pin[0] = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("cap0", 32'(cap[7:0]), 32'h12);
      chk("cap0_flag", 32'(flag[0]), 32'h1);
      @(posedge clk); #2 ch_pin[0] = 0; load_v = 8'h20; load = 1;
      @(posedge clk); #2 load = 0;
      repeat (3) @(posedge clk);
      #2 ch_pin[0] = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("cap0_b", 32'(cap[7:0]), 32'h20);
      chk("cap0_ovr", 32'(ovr[0]), 32'h1);
      @(posedge clk); #2 ch_ack[0] = 1;
      @(posedge clk); #2 ch_ack[0] = 0;
      @(negedge clk);
      chk("cap0_ack", 32'({flag[0], ovr[0]}), 32'h0);

      // compare == 0 with ACK held: iLoad of 0 flags for exactly one cycle
      @(posedge clk); #2;
      ch_mode = 4'b1000; ch_cmp = '0; ch_ack[1] = 1; load_v = 8'h00; load = 1;
      @(posedge clk); #2 load = 0;
      @(negedge clk); chk("cmp_load_pulse", 32'(flag[1]), 32'h1);
      @(posedge clk);
      @(negedge clk); chk("cmp_load_clr", 32'(flag[1]), 32'h0);
      @(posedge clk); #2 ch_ack[1] = 0;

      // randomized phases checked each cycle against the model
      for (int p = 0; p < 50; p++) begin
         in_sel  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
         div_sel = 3'($urandom_range(0, 3));
         ch_mode = 4'($urandom);
         ch_edge = 4'($urandom);
         for (int c = 0; c < NC; c++)
            ch_cmp[W*c +: W] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 6)) : 8'($urandom);
         for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk); #2;
            if ($urandom_range(0, 2) == 0) ev_pin = ~ev_pin;
            for (int c = 0; c < NC; c++)
               if ($urandom_range(0, 3) == 0) ch_pin[c] = ~ch_pin[c];
            load    = ($urandom_range(0, 24) == 0);
            load_v  = ($urandom_range(0, 1) == 1) ? (8'hF0 | 8'($urandom_range(0, 15))) : 8'($urandom);
            ovf_ack = ($urandom_range(0, 3) == 0);
            ch_ack  = 2'($urandom) & {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0};
            rst     = ($urandom_range(0, 299) == 0);
         end
      end
      @(posedge clk); #2 rst = 0;
      @(negedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
